// File: rtl/cam_capture_if.sv
// Frame-buffer write bus produced by the camera capture front end.
interface cam_capture_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] waddr;
    logic [11:0]       wdata;
    logic              wen;

    modport master (output waddr, wdata, wen);
    modport slave  (input  waddr, wdata, wen);
endinterface

// File: rtl/cam_capture.sv
// OV7670 RGB444 capture: oversamples the camera pins in the CLK100MHZ domain and
// emits 12-bit pixels with linear frame-buffer write addresses.
module cam_capture #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 17
) (
    input  logic       CLK100MHZ,
    input  logic       rst_n,
    input  logic       capture_en,
    input  logic       pclk_cam,
    input  logic       vsync_cam,
    input  logic       href_cam,
    input  logic [7:0] wdata_cam,
    cam_capture_if.master wr,
    output logic       frame_done,
    output logic       line_err,
    output logic       frame_err
);
    localparam int X_W = $clog2(H_ACTIVE + 2);
    localparam int Y_W = $clog2(V_ACTIVE + 2);
    localparam logic [X_W-1:0] X_LIM = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] X_SAT = X_W'(H_ACTIVE + 1);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] Y_SAT = Y_W'(V_ACTIVE + 1);

    typedef enum logic [1:0] {SYNC_WAIT, FRAME_WAIT, CAPTURE} state_t;

    // [0],[1] are the synchroniser, [2] is the edge-detect history
    logic [2:0] pclk_sr, vsync_sr, href_sr;
    logic [7:0] data_s1, data_s2;

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            pclk_sr  <= '0;
            vsync_sr <= '0;
            href_sr  <= '0;
            data_s1  <= '0;
            data_s2  <= '0;
        end else begin
            pclk_sr  <= {pclk_sr[1:0], pclk_cam};
            vsync_sr <= {vsync_sr[1:0], vsync_cam};
            href_sr  <= {href_sr[1:0], href_cam};
            data_s1  <= wdata_cam;
            data_s2  <= data_s1;
        end
    end

    logic pclk_rise, href_fall, vsync_rise, vsync_fall, href_s, vsync_s;
    assign href_s     = href_sr[1];
    assign vsync_s    = vsync_sr[1];
    assign pclk_rise  = pclk_sr[1] & ~pclk_sr[2];
    assign href_fall  = ~href_sr[1] & href_sr[2];
    assign vsync_rise = vsync_sr[1] & ~vsync_sr[2];
    assign vsync_fall = ~vsync_sr[1] & vsync_sr[2];

    state_t            state;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addr;
    logic              phase;
    logic [3:0]        red;

    logic [X_W-1:0] x_inc;
    logic [Y_W-1:0] y_line;
    logic           pixel_ok;

    assign x_inc    = (x < X_SAT) ? x + 1'b1 : x;
    assign pixel_ok = (x < X_LIM) && (y < Y_LIM);
    // y after counting the line that href_fall closes; also what vsync_rise judges
    assign y_line   = ((x != '0) && (y < Y_SAT)) ? y + 1'b1 : y;

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC_WAIT;
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            phase      <= 1'b0;
            red        <= '0;
            wr.waddr   <= '0;
            wr.wdata   <= '0;
            wr.wen     <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr.wen     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                SYNC_WAIT: begin
                    if (vsync_s)
                        state <= FRAME_WAIT;
                end
                FRAME_WAIT: begin
                    if (vsync_fall && capture_en) begin
                        x     <= '0;
                        y     <= '0;
                        addr  <= '0;
                        phase <= 1'b0;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (pclk_rise && href_s) begin
                        if (!phase) begin
                            red   <= data_s2[3:0];
                            phase <= 1'b1;
                        end else begin
                            if (pixel_ok) begin
                                wr.wdata <= {red, data_s2};
                                wr.waddr <= addr;
                                wr.wen   <= 1'b1;
                                addr     <= addr + 1'b1;
                            end
                            if (x >= X_LIM)
                                line_err <= 1'b1;
                            x     <= x_inc;
                            phase <= 1'b0;
                        end
                    end
                    // later assignments override the pixel path in the same cycle
                    if (href_fall) begin
                        if (phase)
                            line_err <= 1'b1;
                        y     <= y_line;
                        x     <= '0;
                        phase <= 1'b0;
                    end
                    if (vsync_rise) begin
                        frame_done <= 1'b1;
                        if (y_line != Y_LIM)
                            frame_err <= 1'b1;
                        state <= FRAME_WAIT;
                    end
                end
                default: state <= SYNC_WAIT;
            endcase
        end
    end
endmodule
